div_mem_responder: RTL and testbench

Hardware divide engine that services the start/ack program-launch handshake on behalf of the CPU. It reads an 8-bit dividend and divisor from data memory, computes the quotient and remainder by restoring division, and writes both back. It then raises `ack` for the host or bench. It sits beside the data memory as a second master port. It produces the same memory image the CPU program produces: dividend at 0, divisor at 2, quotient at 4, remainder at 5.

---
 rtl/div_mem_responder.sv | 139 +++++++++++++
 tb/tb_div_mem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div_mem_responder.sv
// Memory-mapped restoring divider: reads dividend/divisor from data memory,
// writes quotient/remainder back, and completes the start/ack launch handshake.
module div_mem_responder #(
   parameter logic [7:0] DVD_ADDR = 8'd0,
   parameter logic [7:0] DVS_ADDR = 8'd2,
   parameter logic [7:0] QUO_ADDR = 8'd4,
   parameter logic [7:0] REM_ADDR = 8'd5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       ack,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rd_data,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RD_DVD = 3'd1;
   localparam logic [2:0] RD_DVS = 3'd2;
   localparam logic [2:0] LATCH  = 3'd3;
   localparam logic [2:0] DIVIDE = 3'd4;
   localparam logic [2:0] WR_QUO = 3'd5;
   localparam logic [2:0] WR_REM = 3'd6;
   localparam logic [2:0] DONE   = 3'd7;

   logic [2:0] state_q, state_d;
   logic       armed_q, armed_d;
   logic [7:0] dvd_q, dvd_d;
   logic [7:0] dvs_q, dvs_d;
   logic [7:0] r_q, r_d;
   logic [7:0] q_q, q_d;
   logic [2:0] cnt_q, cnt_d;

   // The remainder after each step is below the divisor, so only the shifted
   // trial value needs the 9th bit; a zero divisor naturally yields FF / dividend.
   logic [8:0] r_sh;
   logic [8:0] r_sub;
   logic       ge;
   logic [2:0] bit_idx;

   assign bit_idx = 3'd7 - cnt_q;
   assign r_sh    = {r_q, dvd_q[bit_idx]};
   assign r_sub   = r_sh - {1'b0, dvs_q};
   assign ge      = (r_sh >= {1'b0, dvs_q});

   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               armed_d = 1'b0;
               state_d = RD_DVD;
            end
         end
         RD_DVD: state_d = RD_DVS;
         RD_DVS: begin
            dvd_d   = mem_rd_data;
            state_d = LATCH;
         end
         LATCH: begin
            dvs_d   = mem_rd_data;
            r_d     = '0;
            q_d     = '0;
            cnt_d   = '0;
            state_d = DIVIDE;
         end
         DIVIDE: begin
            r_d          = ge ? r_sub[7:0] : r_sh[7:0];
            q_d[bit_idx] = ge;
            cnt_d        = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = WR_QUO;
         end
         WR_QUO: state_d = WR_REM;
         WR_REM: state_d = DONE;
         DONE: begin
            if (start) begin
               armed_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode straight from state so an asynchronous reset drops them at once.
   always_comb begin
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      case (state_q)
         RD_DVD: mem_addr = DVD_ADDR;
         RD_DVS: mem_addr = DVS_ADDR;
         WR_QUO: begin
            mem_addr    = QUO_ADDR;
            mem_wr_en   = 1'b1;
            mem_wr_data = q_q;
         end
         WR_REM: begin
            mem_addr    = REM_ADDR;
            mem_wr_en   = 1'b1;
            mem_wr_data = r_q;
         end
         default: ;
      endcase
   end

   assign ack = (state_q == DONE);

endmodule

// File: tb/tb_div_mem_responder.sv
// Directed bench for div_mem_responder with a synchronous-read memory model.
module tb_div_mem_responder;

   logic       clk;
   logic       reset;
   logic       start;
   logic       ack;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;

   logic       hw_en;
   logic [7:0] hw_addr;
   logic [7:0] hw_data;
   logic [7:0] mem [256];
   int         wr_total;
   int         bad_wr;

   int n_checks;
   int n_pass;

   div_mem_responder #(
      .DVD_ADDR(8'd0),
      .DVS_ADDR(8'd2),
      .QUO_ADDR(8'd4),
      .REM_ADDR(8'd5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ack        (ack),
      .mem_addr   (mem_addr),
      .mem_rd_data(mem_rd_data),
      .mem_wr_en  (mem_wr_en),
      .mem_wr_data(mem_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (hw_en) mem[hw_addr] <= hw_data;
      else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr];
   end

   initial begin
      wr_total = 0;
      bad_wr   = 0;
   end

   always @(posedge clk) begin
      if (mem_wr_en) begin
         wr_total <= wr_total + 1;
         if (mem_addr != 8'd4 && mem_addr != 8'd5) bad_wr <= bad_wr + 1;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
      hw_en   = 1'b1;
      hw_addr = a;
      hw_data = d;
      @(posedge clk);
      #1;
      hw_en = 1'b0;
   endtask

   task automatic run(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                      input int exp_q, input int exp_r, input bit pulse);
      int lat;
      int wr0;
      int bad0;
      start = 1'b1;
      host_wr(8'd0, dvd);
      host_wr(8'd2, dvs);
      wr0  = wr_total;
      bad0 = bad_wr;
      start = 1'b0;
      @(posedge clk);
      #1;
      lat = 0;
      while (!ack && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (pulse && lat == 4) start = 1'b1;
         if (pulse && lat == 6) start = 1'b0;
      end
      check({tag, " latency"}, lat, 13);
      check({tag, " quotient"}, int'(mem[4]), exp_q);
      check({tag, " remainder"}, int'(mem[5]), exp_r);
      check({tag, " write count"}, wr_total - wr0, 2);
      check({tag, " stray writes"}, bad_wr - bad0, 0);
      start = 1'b1;
      @(negedge clk);
      check({tag, " ack held"}, int'(ack), 1);
      @(posedge clk);
      #1;
      check({tag, " ack drop"}, int'(ack), 0);
   endtask

   initial begin
      int ack_seen;
      int wr0;
      n_checks = 0;
      n_pass   = 0;
      hw_en    = 1'b0;
      hw_addr  = '0;
      hw_data  = '0;
      start    = 1'b0;
      reset    = 1'b0;
      #1;
      check("reset ack", int'(ack), 0);
      check("reset wr_en", int'(mem_wr_en), 0);
      check("reset addr", int'(mem_addr), 0);
      check("reset wr_data", int'(mem_wr_data), 0);
      for (int i = 0; i < 16; i++) host_wr(8'(i), 8'(8'hC0 + i));
      reset = 1'b1;
      @(posedge clk);
      #1;

      run("4/2", 8'd4, 8'd2, 2, 0, 1'b0);
      run("255/16", 8'd255, 8'd16, 15, 15, 1'b0);
      check("255/16 dividend kept", int'(mem[0]), 255);
      check("255/16 divisor kept", int'(mem[2]), 16);
      for (int i = 1; i < 16; i++)
         if (i != 2 && i != 4 && i != 5)
            check($sformatf("untouched mem[%0d]", i), int'(mem[i]), 8'hC0 + i);
      run("3/255", 8'd3, 8'd255, 0, 3, 1'b0);
      run("200/1", 8'd200, 8'd1, 200, 0, 1'b0);
      run("7/0", 8'd7, 8'd0, 255, 7, 1'b0);

      // Reset in the middle of a divide.
      host_wr(8'd4, 8'hAA);
      host_wr(8'd5, 8'h55);
      host_wr(8'd0, 8'd20);
      host_wr(8'd2, 8'd3);
      start = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
      end
      wr0   = wr_total;
      reset = 1'b0;
      #1;
      check("midrun reset ack", int'(ack), 0);
      check("midrun reset wr_en", int'(mem_wr_en), 0);
      check("midrun reset addr", int'(mem_addr), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      ack_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (ack) ack_seen++;
      end
      check("no relaunch ack", ack_seen, 0);
      check("no relaunch writes", wr_total - wr0, 0);
      check("reset quo kept", int'(mem[4]), 8'hAA);
      check("reset rem kept", int'(mem[5]), 8'h55);
      run("9/4", 8'd9, 8'd4, 2, 1, 1'b0);

      run("100/7 pulse", 8'd100, 8'd7, 14, 2, 1'b1);
      run("50/50 pulse", 8'd50, 8'd50, 1, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
